rca_seq_adder_ctrl: RTL
=======================

// Module: rca_seq_adder_ctrl
// PURPOSE
//   Multi-cycle wide adder controller. Adds two WIDTH-bit operands by sequencing one
//   4-bit ripple-carry slice over WIDTH/4 nibbles, LSB nibble first, through a carry register.
//   Valid/ready handshake on input and output. Trades latency for area in datapath blocks.
// PARAMETERS
//   WIDTH  16  operand/result width; must be a multiple of 4 and >= 4, else elaboration error ($error)
// PORTS
//   CLK        in   1      single clock, rising edge
//   RST_N      in   1      asynchronous, active-low reset
//   In_Valid   in   1      operands valid
//   In_Ready   out  1      block can accept operands (= state IDLE)
//   A          in   WIDTH  operand A, sampled on input handshake
//   B          in   WIDTH  operand B, sampled on input handshake
//   Cin        in   1      carry-in, sampled on input handshake
//   Sub        in   1      subtract select (present only with RCA_SEQ_SUB_EN)
//   Out_Valid  out  1      Sum/Cout valid
//   Out_Ready  in   1      consumer accepts result
//   Sum        out  WIDTH  result
//   Cout       out  1      carry-out of MSB nibble
//   Busy       out  1      state != IDLE
// BEHAVIOUR
//   - NIB = WIDTH/4; nibble counter width max(1,$clog2(NIB)).
//   - Reset (RST_N=0, async): state IDLE, counter 0, carry reg 0, Sum 0, Cout 0, Out_Valid 0,
//     Busy 0. In_Ready=1 during and after reset (decoded from IDLE).
//   - FSM IDLE -> RUN -> DONE -> IDLE:
//     IDLE: In_Ready=1. On In_Valid&In_Ready: capture A,B,Cin(,Sub); carry reg<=Cin; cnt<=0; -> RUN.
//     RUN : each cycle slice adds A[4k+:4], B[4k+:4], carry reg; Sum[4k+:4]<=slice sum;
//           carry reg<=slice cout; cnt++. After the edge processing k=NIB-1: Cout<=slice cout, -> DONE.
//     DONE: Out_Valid=1; Sum/Cout held stable. On Out_Ready: Out_Valid<=0, -> IDLE.
//   - Latency: Out_Valid rises exactly NIB clock edges after the accepting edge (WIDTH=4: 1 edge).
//   - Throughput: one operation per NIB+2 cycles with Out_Ready held high; no overlap.
//   - In_Ready=0 in RUN/DONE; In_Valid there is ignored, operands not re-sampled.
//   - Out_Ready low in DONE: stall indefinitely, outputs held. Out_Ready in IDLE/RUN: no effect.
//   - Sum bits of nibbles not yet processed hold 0 (cleared on accept) until written.
//   - No combinational path In_Valid->In_Ready or Out_Ready->Out_Valid/In_Ready.
//   - Reset asserted mid-RUN or in DONE: operation aborted, all state returns to reset values.
// CONFIGURATION
//   RCA_SEQ_SUB_EN defined: Sub port exists; when captured Sub=1, B nibbles are inverted before
//     the slice and carry reg<=1 (Cin ignored) -> Sum=A-B mod 2^WIDTH, Cout=1 means no borrow.
//   Not defined: no Sub port; operation is always A+B+Cin.
// STRUCTURE
//   - Package rca_seq_pkg: NIBBLE_W=4 localparam; state enum typedef {IDLE,RUN,DONE} (2 bits).
//   - One sub-module: nibble_add4 (combinational 4-bit ripple-carry slice: a,b,ci -> s,co),
//     instantiated once; controller muxes nibble k into it.
// TESTING (WIDTH=16 unless noted)
//   1. A=0x1234,B=0x4321,Cin=0 -> Sum=0x5555,Cout=0; Out_Valid exactly 4 edges after accept.
//   2. A=0xFFFF,B=0x0001,Cin=0 -> Sum=0x0000,Cout=1 (carry across all nibbles); A=0x000F,B=0,Cin=1 -> 0x0010.
//   3. Out_Ready low 5 cycles in DONE -> Out_Valid,Sum,Cout stable; In_Ready=0; pulsed In_Valid ignored.
//   4. RST_N low after 2 RUN cycles -> Out_Valid=0,Sum=0,Busy=0,In_Ready=1; next op A=1,B=2 -> Sum=3.
//   5. RCA_SEQ_SUB_EN: A=5,B=7,Sub=1 -> Sum=0xFFFE,Cout=0; A=7,B=5,Sub=1 -> Sum=0x0002,Cout=1.
//   6. WIDTH=4: A=0x9,B=0x8 -> Sum=0x1,Cout=1, Out_Valid 1 edge after accept; back-to-back ops, Out_Ready=1.

Source files
------------

// File: rtl/rca_seq_pkg.sv
// rca_seq_pkg
//   Shared definitions for the sequential ripple-carry adder controller:
//   slice width, controller state encoding and the nibble-counter width helper.
//   No ports.
package rca_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must be at least one bit wide, even when there is a single nibble.
  function automatic int cnt_w(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/rca_seq_adder_ctrl_nibble_add4.sv
// nibble_add4
//   Combinational 4-bit ripple-carry adder slice.
//   Ports:
//     i_a, i_b  4-bit addends
//     i_ci      carry in
//     o_s       4-bit sum
//     o_co      carry out of bit 3
module nibble_add4
  import rca_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_ci,
  output logic [NIBBLE_W-1:0] o_s,
  output logic                o_co
);

  logic [NIBBLE_W:0] w_c;

  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_ci;
    for (int i = 0; i < NIBBLE_W; i++) begin
      o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_co = w_c[NIBBLE_W];

endmodule

// File: rtl/rca_seq_adder_ctrl.sv
// rca_seq_adder_ctrl
//   Multi-cycle WIDTH-bit adder: one shared 4-bit ripple-carry slice is stepped
//   over the operand nibbles, LSB first, with the carry kept in a register.
//   Result appears WIDTH/4 edges after the input handshake.
//   Ports:
//     CLK, RST_N          clock (rising edge), async active-low reset
//     In_Valid/In_Ready   operand handshake (In_Ready = state IDLE)
//     A, B, Cin           operands, sampled on the input handshake
//     Sub                 subtract select (only with RCA_SEQ_SUB_EN defined)
//     Out_Valid/Out_Ready result handshake
//     Sum, Cout           result and MSB-nibble carry out
//     Busy                state != IDLE
//   Build option: define RCA_SEQ_SUB_EN to add the Sub port (A-B mode).
module rca_seq_adder_ctrl
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic             Sub,
`endif
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Busy
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = cnt_w(NIB);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("rca_seq_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_carry;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_cout;
  logic                 r_ovalid;
`ifdef RCA_SEQ_SUB_EN
  logic                 r_sub;
`endif

  logic [NIBBLE_W-1:0]  w_a_nib;
  logic [NIBBLE_W-1:0]  w_b_raw;
  logic [NIBBLE_W-1:0]  w_b_nib;
  logic [NIBBLE_W-1:0]  w_s;
  logic                 w_co;
  logic                 w_start_carry;

  // Controller selects nibble r_cnt of each captured operand for the slice.
  assign w_a_nib = r_a[int'(r_cnt)*NIBBLE_W +: NIBBLE_W];
  assign w_b_raw = r_b[int'(r_cnt)*NIBBLE_W +: NIBBLE_W];

`ifdef RCA_SEQ_SUB_EN
  // Subtract as A + ~B + 1: invert B per nibble, force the initial carry.
  assign w_b_nib       = r_sub ? ~w_b_raw : w_b_raw;
  assign w_start_carry = Sub ? 1'b1 : Cin;
`else
  assign w_b_nib       = w_b_raw;
  assign w_start_carry = Cin;
`endif

  nibble_add4 u_slice (
    .i_a  (w_a_nib),
    .i_b  (w_b_nib),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  // Handshake outputs decode registered state only, so no input-to-ready path.
  assign In_Ready  = (r_state == IDLE);
  assign Busy      = (r_state != IDLE);
  assign Out_Valid = r_ovalid;
  assign Sum       = r_sum;
  assign Cout      = r_cout;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovalid <= 1'b0;
`ifdef RCA_SEQ_SUB_EN
      r_sub    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (In_Valid) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= w_start_carry;
            r_cnt   <= '0;
            r_sum   <= '0;  // unprocessed nibbles read as zero
`ifdef RCA_SEQ_SUB_EN
            r_sub   <= Sub;
`endif
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[int'(r_cnt)*NIBBLE_W +: NIBBLE_W] <= w_s;
          r_carry <= w_co;
          if (r_cnt == LAST) begin
            r_cout   <= w_co;
            r_ovalid <= 1'b1;
            r_cnt    <= '0;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (Out_Ready) begin
            r_ovalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_ovalid <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule
